// File: rtl/tx_rs232_fifo.sv
// Buffered 8N1 RS-232 transmitter.
// Bytes enter over a valid/ready handshake, wait in a small circular FIFO and
// are serialized LSB first on oTX: a start bit, 8 data bits and a stop bit,
// each CLKS_PER_BIT clk_s cycles long. Frames run back-to-back while the FIFO
// holds data.
module tx_rs232_fifo #(
    parameter int CLKS_PER_BIT = 6,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk_s,
    input  logic               rst_s,
    input  logic [7:0]         iDATA,
    input  logic               iVALID,
    output logic               oREADY,
    output logic               oTX,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [FIFO_AW:0]   oCOUNT
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [15:0]      BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic               push;
    logic               pop;
    logic               tick;
    logic               fifo_nonempty;
    logic               tx_next;

    assign fifo_nonempty = (oCOUNT != '0);
    assign oREADY        = (oCOUNT != FULL_COUNT);
    assign push          = iVALID && oREADY;
    // Last cycle of the current bit period.
    assign tick          = (baud_cnt == BAUD_LAST);

    // State register.
    always_ff @(posedge clk_s) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples the pre-edge values of its peers.
        if (rst_s) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: walk START -> DATA -> STOP, chaining frames while the FIFO has data.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:  if (fifo_nonempty) state_next = START;
            START: if (tick) state_next = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (tick) state_next = fifo_nonempty ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control logic: FIFO pop, busy flag and the next serial line level.
    always_comb begin
        pop     = 1'b0;
        oBUSY   = 1'b1;
        tx_next = 1'b1;
        case (state)
            IDLE: begin
                oBUSY   = 1'b0;
                pop     = fifo_nonempty;
                tx_next = !fifo_nonempty;
            end
            START: begin
                tx_next = tick ? shift[0] : 1'b0;
            end
            DATA: begin
                if (tick) begin
                    tx_next = (bit_idx == 3'd7) ? 1'b1 : shift[1];
                end else begin
                    tx_next = shift[0];
                end
            end
            STOP: begin
                pop     = tick && fifo_nonempty;
                tx_next = !(tick && fifo_nonempty);
            end
            default: begin
                oBUSY   = 1'b0;
            end
        endcase
    end

    // FIFO storage.
    always_ff @(posedge clk_s) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // occupancy counter alone define which entries are valid.
        if (push) begin
            mem[wr_ptr] <= iDATA;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            oCOUNT <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                oCOUNT <= oCOUNT + COUNT_ONE;
            end else if (pop && !push) begin
                oCOUNT <= oCOUNT - COUNT_ONE;
            end
        end
    end

    // Serializer: baud counter, shift register, bit index, registered line and done pulse.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            oTX      <= 1'b1;
            oDONE    <= 1'b0;
        end else begin
            oTX   <= tx_next;
            oDONE <= (state == STOP) && tick;

            if (state == IDLE || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_rs232_fifo.sv
// Directed bench for tx_rs232_fifo (CLKS_PER_BIT=6, 4-entry FIFO).
// A line receiver in the bench decodes every frame on oTX and the decoded
// bytes are compared against the bytes the bench pushed.
module tb_tx_rs232_fifo;

    localparam int C = 6;

    logic       clk_s = 1'b0;
    logic       rst_s = 1'b1;
    logic [7:0] iDATA = 8'h00;
    logic       iVALID = 1'b0;
    logic       oREADY;
    logic       oTX;
    logic       oBUSY;
    logic       oDONE;
    logic [2:0] oCOUNT;

    tx_rs232_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_AW      (2)
    ) dut (
        .clk_s  (clk_s),
        .rst_s  (rst_s),
        .iDATA  (iDATA),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oTX    (oTX),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE),
        .oCOUNT (oCOUNT)
    );

    always #5 clk_s = ~clk_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Running statistics, sampled on the falling edge.
    int cyc         = 0;
    int busy_cycles = 0;
    int done_cnt    = 0;
    int low_cycles  = 0;
    int ready_err   = 0;
    int done_q[$];

    // Receiver state.
    int         frame_err = 0;
    logic       aborted   = 1'b0;
    logic [7:0] rx_q[$];

    // Main-thread bookkeeping.
    logic [7:0] exp_q[$];
    int peak   = 0;
    int stalls = 0;
    int rx_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_s) begin
        cyc++;
        if (oBUSY === 1'b1) busy_cycles++;
        if (oDONE === 1'b1) begin
            done_cnt++;
            done_q.push_back(cyc);
        end
        if (oTX === 1'b0) low_cycles++;
        if (!rst_s && oREADY !== (oCOUNT != 3'd4)) ready_err++;
    end

    task automatic mon_wait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_s);
            if (rst_s) aborted = 1'b1;
        end
    endtask

    // Line receiver: samples each bit in the middle of its period.
    always begin : rx_monitor
        logic [7:0] b;
        @(negedge clk_s);
        if (oTX === 1'b0 && rst_s === 1'b0) begin
            aborted = 1'b0;
            b = 8'h00;
            mon_wait(C / 2);
            if (!aborted && oTX !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                mon_wait(C);
                b[i] = oTX;
            end
            mon_wait(C);
            if (!aborted) begin
                if (oTX !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    // Called at posedge+2; holds iVALID until the byte is accepted, returns at accept edge+2.
    task automatic push(input logic [7:0] b);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        iDATA  = b;
        iVALID = 1'b1;
        do begin
            @(negedge clk_s);
            rdy = oREADY;
            if (int'(oCOUNT) > peak) peak = int'(oCOUNT);
            if (!rdy) stalls++;
            @(posedge clk_s);
            n++;
        end while (!rdy && n < 500);
        #2;
        iVALID = 1'b0;
        if (rdy) exp_q.push_back(b);
        else check("push_accept", 32'(rdy), 32'd1);
    endtask

    task automatic wait_idle();
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        while (n < 2000 && !ok) begin
            @(negedge clk_s);
            n++;
            if (int'(oCOUNT) > peak) peak = int'(oCOUNT);
            if (oBUSY === 1'b0 && oCOUNT === 3'd0) ok = 1'b1;
        end
        check("idle_wait", 32'(ok), 32'd1);
        repeat (8) @(negedge clk_s);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_chk < rx_q.size() && rx_chk < exp_q.size()) begin
            check({tag, "_rx_byte"}, 32'(rx_q[rx_chk]), 32'(exp_q[rx_chk]));
            rx_chk++;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [59:0] cap;
        logic [59:0] exp_bits;
        int base_busy;
        int base_done;
        int base_stall;
        int base_rerr;
        int base_low;
        int nd;

        // Reset.
        rst_s = 1'b1;
        repeat (3) @(posedge clk_s);
        #2 rst_s = 1'b0;
        @(negedge clk_s);
        check("rst_tx",    32'(oTX),    32'd1);
        check("rst_busy",  32'(oBUSY),  32'd0);
        check("rst_done",  32'(oDONE),  32'd0);
        check("rst_count", 32'(oCOUNT), 32'd0);
        check("rst_ready", 32'(oREADY), 32'd1);

        // Single byte 0x55: line shows 0,1,0,1,... each level for 6 cycles.
        @(posedge clk_s); #2;
        push(8'h55);
        @(negedge clk_s);
        check("t1_count_after_accept", 32'(oCOUNT), 32'd1);
        check("t1_tx_still_idle",      32'(oTX),    32'd1);
        @(negedge clk_s);
        check("t1_start_fall", 32'(oTX),    32'd0);
        check("t1_busy",       32'(oBUSY),  32'd1);
        check("t1_popped",     32'(oCOUNT), 32'd0);
        for (int i = 0; i < 60; i++) begin
            cap[i]      = oTX;
            exp_bits[i] = 1'((i / C) % 2);
            @(negedge clk_s);
        end
        check("t1_bits_lo", 32'(cap[29:0]),  32'(exp_bits[29:0]));
        check("t1_bits_hi", 32'(cap[59:30]), 32'(exp_bits[59:30]));
        check("t1_done_pulse", 32'(oDONE),  32'd1);
        check("t1_busy_end",   32'(oBUSY),  32'd0);
        check("t1_tx_idle",    32'(oTX),    32'd1);
        check("t1_count_end",  32'(oCOUNT), 32'd0);
        @(negedge clk_s);
        check("t1_done_one_cycle", 32'(oDONE), 32'd0);
        wait_idle();
        check_rx("t1");

        // Four bytes on consecutive cycles: back-to-back frames.
        @(posedge clk_s); #2;
        base_busy = busy_cycles;
        base_done = done_cnt;
        peak = 0;
        push(8'hA3);
        push(8'h0F);
        push(8'hFF);
        push(8'h00);
        @(negedge clk_s);
        if (int'(oCOUNT) > peak) peak = int'(oCOUNT);
        wait_idle();
        nd = done_q.size();
        check("t2_peak_count",  32'(peak),                      32'd3);
        check("t2_busy_cycles", 32'(busy_cycles - base_busy),   32'd240);
        check("t2_done_pulses", 32'(done_cnt - base_done),      32'd4);
        check("t2_done_span",   32'(done_q[nd-1] - done_q[nd-4]), 32'd180);
        check("t2_done_gap",    32'(done_q[nd-1] - done_q[nd-2]), 32'd60);
        check_rx("t2");

        // Fill the FIFO while busy: sixth byte stalls until the first frame ends.
        @(posedge clk_s); #2;
        base_busy  = busy_cycles;
        base_done  = done_cnt;
        base_stall = stalls;
        base_rerr  = ready_err;
        peak = 0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h66);
        push(8'h77);
        wait_idle();
        check("t3_peak_count",  32'(peak),                    32'd4);
        check("t3_stall_cycles", 32'(stalls - base_stall),    32'd57);
        check("t3_ready_vs_count", 32'(ready_err - base_rerr), 32'd0);
        check("t3_busy_cycles", 32'(busy_cycles - base_busy), 32'd360);
        check("t3_done_pulses", 32'(done_cnt - base_done),    32'd6);
        check_rx("t3");

        // Push on the exact edge IDLE pops: count holds at 1, frames chain.
        @(posedge clk_s); #2;
        base_busy = busy_cycles;
        base_done = done_cnt;
        push(8'h81);
        push(8'h7E);
        @(negedge clk_s);
        check("t4_count_held", 32'(oCOUNT), 32'd1);
        check("t4_busy",       32'(oBUSY),  32'd1);
        check("t4_start",      32'(oTX),    32'd0);
        wait_idle();
        nd = done_q.size();
        check("t4_busy_cycles", 32'(busy_cycles - base_busy),   32'd120);
        check("t4_done_pulses", 32'(done_cnt - base_done),      32'd2);
        check("t4_done_gap",    32'(done_q[nd-1] - done_q[nd-2]), 32'd60);
        check_rx("t4");

        // Reset during data bit 4 of 0xC6 with two bytes queued.
        @(posedge clk_s); #2;
        base_done = done_cnt;
        push(8'hC6);
        push(8'h5A);
        push(8'hA5);
        repeat (29) @(posedge clk_s);
        @(negedge clk_s);
        check("t5_bit4_level", 32'(oTX),    32'd0);
        check("t5_queued",     32'(oCOUNT), 32'd2);
        @(posedge clk_s); #2;
        rst_s = 1'b1;
        @(posedge clk_s); #2;
        rst_s = 1'b0;
        @(negedge clk_s);
        check("t5_tx",    32'(oTX),    32'd1);
        check("t5_busy",  32'(oBUSY),  32'd0);
        check("t5_count", 32'(oCOUNT), 32'd0);
        check("t5_done",  32'(oDONE),  32'd0);
        check("t5_ready", 32'(oREADY), 32'd1);
        base_low = low_cycles;
        repeat (70) @(negedge clk_s);
        check("t5_line_idle", 32'(low_cycles - base_low), 32'd0);
        check("t5_no_done",   32'(done_cnt - base_done),  32'd0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        check_rx("t5");

        // Loopback into the line receiver.
        @(posedge clk_s); #2;
        base_done = done_cnt;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        push(8'h78);
        wait_idle();
        check("t6_done_pulses", 32'(done_cnt - base_done), 32'd4);
        check_rx("t6");
        check("framing_errors", 32'(frame_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
